mult_precise: RTL and testbench



---
 rtl/mult_precise.sv | 101 ++++++++++
 tb/tb_mult_precise.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_precise.sv
// Single-precision binary32 multiplier with one registered output stage.
// Define MULT_PRECISE_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module mult_precise (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   output logic        out_valid,
   output logic [31:0] result,
   output logic        Exception,
   output logic        Overflow,
   output logic        Underflow
);

   localparam int DATA_W = 32;
   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int SIG_W  = MAN_W + 1;
   localparam int PROD_W = 2 * SIG_W;

   // Returns {carry, significand}; carry is set only when rounding overflows the 24-bit field.
   function automatic logic [SIG_W:0] round_sig(input logic [PROD_W-1:0] prod, input logic norm);
`ifdef MULT_PRECISE_RNE_EN
      logic [SIG_W-1:0] sig;
      logic             guard;
      logic             sticky;
      if (norm) begin
         sig    = prod[PROD_W-1:PROD_W-SIG_W];
         guard  = prod[PROD_W-SIG_W-1];
         sticky = |prod[PROD_W-SIG_W-2:0];
      end else begin
         sig    = prod[PROD_W-2:PROD_W-SIG_W-1];
         guard  = prod[PROD_W-SIG_W-2];
         sticky = |prod[PROD_W-SIG_W-3:0];
      end
      return {1'b0, sig} + (SIG_W+1)'(guard & (sticky | sig[0]));
`else
      return norm ? {1'b0, prod[PROD_W-1:PROD_W-SIG_W]} : {1'b0, prod[PROD_W-2:PROD_W-SIG_W-1]};
`endif
   endfunction

   logic                     sign_p0;
   logic [EXP_W-1:0]         ea_p0;
   logic [EXP_W-1:0]         eb_p0;
   logic [SIG_W-1:0]         sig_a_p0;
   logic [SIG_W-1:0]         sig_b_p0;
   logic [PROD_W-1:0]        prod_p0;
   logic                     norm_p0;
   logic [SIG_W:0]           rnd_p0;
   logic [MAN_W-1:0]         mant_p0;
   logic signed [9:0]        exp_p0;
   logic                     zero_p0;
   logic                     exc_p0;
   logic                     ovf_p0;
   logic                     unf_p0;
   logic [DATA_W-1:0]        res_p0;

   // Stage p0: combinational unpack, multiply, normalise, round and classify
   always_comb begin
      sign_p0  = a_operand[31] ^ b_operand[31];
      ea_p0    = a_operand[30:23];
      eb_p0    = b_operand[30:23];
      sig_a_p0 = {|ea_p0, a_operand[MAN_W-1:0]};
      sig_b_p0 = {|eb_p0, b_operand[MAN_W-1:0]};
      prod_p0  = PROD_W'(sig_a_p0) * PROD_W'(sig_b_p0);
      norm_p0  = prod_p0[PROD_W-1];
      rnd_p0   = round_sig(prod_p0, norm_p0);
      mant_p0  = rnd_p0[SIG_W] ? rnd_p0[SIG_W-1:1] : rnd_p0[MAN_W-1:0];
      exp_p0   = signed'({2'b00, ea_p0}) + signed'({2'b00, eb_p0}) - 10'sd127
               + signed'({9'b0, norm_p0}) + signed'({9'b0, rnd_p0[SIG_W]});
      zero_p0  = ~|a_operand[30:0] | ~|b_operand[30:0];
      exc_p0   = (&ea_p0) | (&eb_p0);
      ovf_p0   = (exp_p0 >= 10'sd255) & ~zero_p0;
      unf_p0   = (exp_p0 <= 10'sd0) & ~zero_p0;
      if (exc_p0 | ovf_p0 | unf_p0)
         res_p0 = '0;
      else if (zero_p0)
         res_p0 = {sign_p0, 31'b0};
      else
         res_p0 = {sign_p0, exp_p0[EXP_W-1:0], mant_p0};
   end

   // Stage p1: output registers load every cycle; out_valid qualifies them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         Exception <= 1'b0;
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         out_valid <= in_valid;
         result    <= res_p0;
         Exception <= exc_p0;
         Overflow  <= ovf_p0;
         Underflow <= unf_p0;
      end
   end

endmodule

// File: tb/tb_mult_precise.sv
// Self-checking bench for mult_precise: directed vectors, boundaries, randomized traffic, reset.
module tb_mult_precise;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] a_operand = '0;
   logic [31:0] b_operand = '0;
   logic        out_valid;
   logic [31:0] result;
   logic        Exception;
   logic        Overflow;
   logic        Underflow;

   int n_cmp = 0;
   int n_err = 0;

   mult_precise dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a_operand(a_operand), .b_operand(b_operand),
      .out_valid(out_valid), .result(result),
      .Exception(Exception), .Overflow(Overflow), .Underflow(Underflow)
   );

   always #5 clk = ~clk;

   // Reference: exact integer product of the significands, scaled and rounded arithmetically.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
      int              ea, eb, e, shift, norm;
      longint unsigned ma, mb, p, q;
      bit              zero, exc, ovf, unf;
      logic [31:0]     r;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = longint'(a[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
      mb = longint'(b[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
      p  = ma * mb;
      if (p >= 64'd140737488355328) begin shift = 24; norm = 1; end
      else begin shift = 23; norm = 0; end
      q = p / (64'd1 << shift);
`ifdef MULT_PRECISE_RNE_EN
      begin
         longint unsigned rem, half;
         rem  = p - q * (64'd1 << shift);
         half = 64'd1 << (shift - 1);
         if (rem > half || (rem == half && q % 2 == 1)) q = q + 1;
         if (q == 64'd16777216) begin q = q / 2; norm = norm + 1; end
      end
`endif
      e    = ea + eb - 127 + norm;
      zero = (a[30:0] == 0) || (b[30:0] == 0);
      exc  = (ea == 255) || (eb == 255);
      ovf  = (e >= 255) && !zero;
      unf  = (e <= 0) && !zero;
      if (exc || ovf || unf) r = 32'h0;
      else if (zero) r = {a[31] ^ b[31], 31'b0};
      else r = {a[31] ^ b[31], 8'(e), 23'(q % 64'd8388608)};
      return {exc, ovf, unf, r};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      int sel;
      v   = $urandom;
      sel = $urandom_range(0, 15);
      case (sel)
         0: v[30:0] = '0;
         1: v[30:23] = 8'hFF;
         2: ;
         3: v[30:23] = 8'($urandom_range(0, 3));
         4: v[30:23] = 8'($urandom_range(250, 254));
         default: v[30:23] = 8'($urandom_range(100, 154));
      endcase
      return v;
   endfunction

   task automatic test_reset();
      logic [35:0] got;
      rst_n = 1'b0;
      in_valid = 1'b1;
      a_operand = 32'h4000_0000;
      b_operand = 32'h4040_0000;
      repeat (3) @(posedge clk);
      #1;
      got = {out_valid, Exception, Overflow, Underflow, result};
      n_cmp++;
      if (got !== 36'h0) begin
         n_err++;
         $display("FAIL reset_state got=%h expected=%h", got, 36'h0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] ta [12];
      logic [31:0] tb [12];
      logic [35:0] te [12];
      logic [35:0] got;
      ta[0]  = 32'h4580_0000; tb[0]  = 32'h4580_0000; te[0]  = {4'b1000, 32'h4B80_0000};
      ta[1]  = 32'h4000_0000; tb[1]  = 32'h4040_0000; te[1]  = {4'b1000, 32'h40C0_0000};
      ta[2]  = 32'hBFC0_0000; tb[2]  = 32'h4000_0000; te[2]  = {4'b1000, 32'hC040_0000};
      ta[3]  = 32'h0000_0000; tb[3]  = 32'h0000_0000; te[3]  = {4'b1000, 32'h0000_0000};
      ta[4]  = 32'hC152_6666; tb[4]  = 32'h0000_0000; te[4]  = {4'b1000, 32'h8000_0000};
      ta[5]  = 32'h7F80_0000; tb[5]  = 32'h7F80_0000; te[5]  = {4'b1110, 32'h0000_0000};
      ta[6]  = 32'h0080_0000; tb[6]  = 32'h0018_0000; te[6]  = {4'b1001, 32'h0000_0000};
      ta[7]  = 32'h7F00_0000; tb[7]  = 32'h3F80_0000; te[7]  = {4'b1000, 32'h7F00_0000};
      ta[8]  = 32'h7F00_0000; tb[8]  = 32'h4000_0000; te[8]  = {4'b1010, 32'h0000_0000};
      ta[9]  = 32'h0080_0000; tb[9]  = 32'h3F80_0000; te[9]  = {4'b1000, 32'h0080_0000};
      ta[10] = 32'h0080_0000; tb[10] = 32'h3F00_0000; te[10] = {4'b1001, 32'h0000_0000};
      ta[11] = 32'h7F80_0000; tb[11] = 32'h0000_0000; te[11] = {4'b1100, 32'h0000_0000};
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a_operand = ta[i];
         b_operand = tb[i];
         @(posedge clk);
         #1;
         got = {out_valid, Exception, Overflow, Underflow, result};
         n_cmp++;
         if (got !== te[i]) begin
            n_err++;
            $display("FAIL directed[%0d] a=%h b=%h got=%h expected=%h", i, ta[i], tb[i], got, te[i]);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [35:0] got, exp;
      logic        v;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         v = ($urandom_range(0, 3) != 0);
         in_valid = v;
         a_operand = rand_op();
         b_operand = rand_op();
         exp = {v, model(a_operand, b_operand)};
         @(posedge clk);
         #1;
         got = {out_valid, Exception, Overflow, Underflow, result};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL random[%0d] a=%h b=%h got=%h expected=%h", i, a_operand, b_operand, got, exp);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midop();
      logic [35:0] got;
      @(negedge clk);
      in_valid = 1'b1;
      a_operand = 32'h4000_0000;
      b_operand = 32'h4040_0000;
      @(posedge clk);
      #1;
      got = {out_valid, Exception, Overflow, Underflow, result};
      n_cmp++;
      if (got !== {4'b1000, 32'h40C0_0000}) begin
         n_err++;
         $display("FAIL pre_reset_op got=%h expected=%h", got, {4'b1000, 32'h40C0_0000});
      end
      @(negedge clk);
      a_operand = 32'hBFC0_0000;
      b_operand = 32'h4000_0000;
      #2;
      rst_n = 1'b0;
      #1;
      got = {out_valid, Exception, Overflow, Underflow, result};
      n_cmp++;
      if (got !== 36'h0) begin
         n_err++;
         $display("FAIL async_reset_immediate got=%h expected=%h", got, 36'h0);
      end
      @(posedge clk);
      #1;
      got = {out_valid, Exception, Overflow, Underflow, result};
      n_cmp++;
      if (got !== 36'h0) begin
         n_err++;
         $display("FAIL reset_discard got=%h expected=%h", got, 36'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a_operand = 32'h4580_0000;
      b_operand = 32'h4580_0000;
      @(posedge clk);
      #1;
      got = {out_valid, Exception, Overflow, Underflow, result};
      n_cmp++;
      if (got !== {4'b1000, 32'h4B80_0000}) begin
         n_err++;
         $display("FAIL post_reset_op got=%h expected=%h", got, {4'b1000, 32'h4B80_0000});
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL valid_drop got=%b expected=0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
